// File: rtl/stream_demux12.sv
// stream_demux12: routes whole valid/ready packets to one of two outputs, each behind a one-entry register slice.
// The route is latched on a packet's first beat and held until its last beat is accepted.
module stream_demux12 #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    input  logic          in_sel,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [DW-1:0] out0_data,
    output logic          out0_last,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [DW-1:0] out1_data,
    output logic          out1_last,
    output logic [CW-1:0] pkt_cnt0,
    output logic [CW-1:0] pkt_cnt1
);
    typedef enum logic [1:0] {IDLE, PKT0, PKT1} state_t;

    state_t        state_q, state_d;
    logic          v0_q, v0_d, v1_q, v1_d;
    logic          l0_q, l0_d, l1_q, l1_d;
    logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
    logic [CW-1:0] c0_q, c0_d, c1_q, c1_d;
    logic          sel, acc, wr0, wr1;

    // Only the selected output's slice gates the input; the other keeps draining on its own.
    always_comb begin
        sel      = (state_q == IDLE) ? in_sel : (state_q == PKT1);
        in_ready = sel ? (!v1_q || out1_ready) : (!v0_q || out0_ready);
        acc      = in_valid && in_ready;
        wr0      = acc && !sel;
        wr1      = acc && sel;
        state_d  = acc ? (in_last ? IDLE : (sel ? PKT1 : PKT0)) : state_q;
        v0_d     = wr0 ? 1'b1 : (out0_ready ? 1'b0 : v0_q);
        v1_d     = wr1 ? 1'b1 : (out1_ready ? 1'b0 : v1_q);
        d0_d     = wr0 ? in_data : d0_q;
        d1_d     = wr1 ? in_data : d1_q;
        l0_d     = wr0 ? in_last : l0_q;
        l1_d     = wr1 ? in_last : l1_q;
        c0_d     = c0_q + CW'(wr0 && in_last);
        c1_d     = c1_q + CW'(wr1 && in_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            d0_q    <= '0;
            d1_q    <= '0;
            l0_q    <= 1'b0;
            l1_q    <= 1'b0;
            c0_q    <= '0;
            c1_q    <= '0;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            d0_q    <= d0_d;
            d1_q    <= d1_d;
            l0_q    <= l0_d;
            l1_q    <= l1_d;
            c0_q    <= c0_d;
            c1_q    <= c1_d;
        end
    end

    assign out0_valid = v0_q;
    assign out0_data  = d0_q;
    assign out0_last  = l0_q;
    assign out1_valid = v1_q;
    assign out1_data  = d1_q;
    assign out1_last  = l1_q;
    assign pkt_cnt0   = c0_q;
    assign pkt_cnt1   = c1_q;
endmodule

// File: tb/tb_stream_demux12.sv
// tb_stream_demux12: directed scenario tasks for stream_demux12 with hand-computed expectations.
module tb_stream_demux12;
    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, in_last, in_sel;
    logic [7:0] in_data;
    logic       out0_valid, out0_ready, out0_last;
    logic       out1_valid, out1_ready, out1_last;
    logic [7:0] out0_data, out1_data, pkt_cnt0, pkt_cnt1;
    int         checks = 0;
    int         failures = 0;

    stream_demux12 #(.DW(8), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_sel(in_sel),
        .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out0_data(out0_data), .out0_last(out0_last),
        .out1_valid(out1_valid), .out1_ready(out1_ready),
        .out1_data(out1_data), .out1_last(out1_last),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [7:0] d, input logic l);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        in_last  = l;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        checks++; if ({out0_valid, out1_valid} !== 2'b00) begin failures++; $display("FAIL reset_valid got=%b want=00", {out0_valid, out1_valid}); end
        checks++; if ({out0_data, out1_data} !== 16'h0) begin failures++; $display("FAIL reset_data got=%h want=0000", {out0_data, out1_data}); end
        checks++; if ({out0_last, out1_last} !== 2'b00) begin failures++; $display("FAIL reset_last got=%b want=00", {out0_last, out1_last}); end
        checks++; if ({pkt_cnt0, pkt_cnt1} !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h want=0000", {pkt_cnt0, pkt_cnt1}); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_single();
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        drive(1'b1, 1'b0, 8'hA5, 1'b1);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b want=1", in_ready); end
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if ({out0_valid, out0_data, out0_last} !== {1'b1, 8'hA5, 1'b1}) begin failures++; $display("FAIL single_out0 got=%b/%h/%b want=1/a5/1", out0_valid, out0_data, out0_last); end
        checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL single_out1_valid got=%b want=0", out1_valid); end
        checks++; if ({pkt_cnt0, pkt_cnt1} !== {8'd1, 8'd0}) begin failures++; $display("FAIL single_cnt got=%0d/%0d want=1/0", pkt_cnt0, pkt_cnt1); end
        step();
        checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b want=0", out0_valid); end
    endtask

    task automatic test_sticky();
        logic [7:0] exp_d [3];
        exp_d = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, (i == 0), exp_d[i], (i == 2));
            step();
            checks++; if ({out1_valid, out1_data, out1_last} !== {1'b1, exp_d[i], (i == 2)}) begin failures++; $display("FAIL sticky_out1_beat%0d got=%b/%h/%b want=1/%h/%b", i, out1_valid, out1_data, out1_last, exp_d[i], (i == 2)); end
            checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL sticky_out0_beat%0d got=%b want=0", i, out0_valid); end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if ({pkt_cnt0, pkt_cnt1} !== {8'd1, 8'd1}) begin failures++; $display("FAIL sticky_cnt got=%0d/%0d want=1/1", pkt_cnt0, pkt_cnt1); end
        step();
        checks++; if (out1_valid !== 1'b0) begin failures++; $display("FAIL sticky_drain got=%b want=0", out1_valid); end
    endtask

    task automatic test_backpressure();
        out0_ready = 1'b0;
        drive(1'b1, 1'b0, 8'h01, 1'b0);
        step();
        drive(1'b1, 1'b0, 8'h02, 1'b1);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b want=0", in_ready); end
        step();
        checks++; if ({out0_valid, out0_data, out0_last} !== {1'b1, 8'h01, 1'b0}) begin failures++; $display("FAIL bp_hold got=%b/%h/%b want=1/01/0", out0_valid, out0_data, out0_last); end
        checks++; if (pkt_cnt0 !== 8'd1) begin failures++; $display("FAIL bp_cnt_stalled got=%0d want=1", pkt_cnt0); end
        out0_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_high got=%b want=1", in_ready); end
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if ({out0_valid, out0_data, out0_last} !== {1'b1, 8'h02, 1'b1}) begin failures++; $display("FAIL bp_second got=%b/%h/%b want=1/02/1", out0_valid, out0_data, out0_last); end
        step();
        checks++; if (out0_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b want=0", out0_valid); end
        checks++; if (pkt_cnt0 !== 8'd2) begin failures++; $display("FAIL bp_cnt got=%0d want=2", pkt_cnt0); end
    endtask

    task automatic test_independence();
        out1_ready = 1'b0;
        drive(1'b1, 1'b1, 8'hAA, 1'b1);
        step();
        drive(1'b1, 1'b0, 8'hB1, 1'b0);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ind_ready_first got=%b want=1", in_ready); end
        step();
        checks++; if ({out0_valid, out0_data} !== {1'b1, 8'hB1}) begin failures++; $display("FAIL ind_out0_b1 got=%b/%h want=1/b1", out0_valid, out0_data); end
        drive(1'b1, 1'b1, 8'hB2, 1'b1);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ind_ready_second got=%b want=1", in_ready); end
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if ({out0_valid, out0_data, out0_last} !== {1'b1, 8'hB2, 1'b1}) begin failures++; $display("FAIL ind_out0_b2 got=%b/%h/%b want=1/b2/1", out0_valid, out0_data, out0_last); end
        checks++; if ({out1_valid, out1_data, out1_last} !== {1'b1, 8'hAA, 1'b1}) begin failures++; $display("FAIL ind_out1_hold got=%b/%h/%b want=1/aa/1", out1_valid, out1_data, out1_last); end
        checks++; if ({pkt_cnt0, pkt_cnt1} !== {8'd3, 8'd2}) begin failures++; $display("FAIL ind_cnt got=%0d/%0d want=3/2", pkt_cnt0, pkt_cnt1); end
        out1_ready = 1'b1;
        step();
        checks++; if ({out0_valid, out1_valid} !== 2'b00) begin failures++; $display("FAIL ind_drain got=%b want=00", {out0_valid, out1_valid}); end
    endtask

    task automatic test_wrap();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b1);
            step();
            if (i % 64 == 3) begin
                checks++; if (out0_data !== 8'(i)) begin failures++; $display("FAIL wrap_data%0d got=%h want=%h", i, out0_data, 8'(i)); end
            end
            if (i == 254) begin
                checks++; if (pkt_cnt0 !== 8'd255) begin failures++; $display("FAIL wrap_cnt_max got=%0d want=255", pkt_cnt0); end
            end
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if ({pkt_cnt0, pkt_cnt1} !== 16'h0) begin failures++; $display("FAIL wrap_cnt got=%0d/%0d want=0/0", pkt_cnt0, pkt_cnt1); end
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 8'hC1, 1'b0);
        step();
        drive(1'b1, 1'b1, 8'hC2, 1'b0);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if ({out0_valid, out1_valid} !== 2'b00) begin failures++; $display("FAIL rmid_valid got=%b want=00", {out0_valid, out1_valid}); end
        checks++; if ({pkt_cnt0, pkt_cnt1} !== 16'h0) begin failures++; $display("FAIL rmid_cnt got=%0d/%0d want=0/0", pkt_cnt0, pkt_cnt1); end
        drive(1'b1, 1'b0, 8'hD1, 1'b0);
        step();
        checks++; if ({out0_valid, out0_data, out1_valid} !== {1'b1, 8'hD1, 1'b0}) begin failures++; $display("FAIL rmid_route got=%b/%h/%b want=1/d1/0", out0_valid, out0_data, out1_valid); end
        drive(1'b1, 1'b1, 8'hD2, 1'b1);
        step();
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        checks++; if ({out0_valid, out0_data, out0_last, out1_valid} !== {1'b1, 8'hD2, 1'b1, 1'b0}) begin failures++; $display("FAIL rmid_last got=%b/%h/%b/%b want=1/d2/1/0", out0_valid, out0_data, out0_last, out1_valid); end
        checks++; if ({pkt_cnt0, pkt_cnt1} !== {8'd1, 8'd0}) begin failures++; $display("FAIL rmid_cnt_after got=%0d/%0d want=1/0", pkt_cnt0, pkt_cnt1); end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_sel = 1'b0;
        in_data = 8'h00;
        in_last = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        test_reset();
        test_single();
        test_sticky();
        test_backpressure();
        test_independence();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stream_demux12.md
Name: stream_demux12

Overview:
- 1-to-2 stream demultiplexer: the splitting counterpart of the team's 2:1 select mux.
- Accepts one valid/ready input stream of packets and routes each whole packet to output 0 or output 1.
- The route is chosen by a select bit sampled on the packet's first beat.
- Each output has a one-entry register slice; the block sits between a shared producer and two downstream consumers.

Parameters:
- DW, 8, data width in bits.
- CW, 8, width of each per-output packet counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  DW  input beat data.
- in_last  input  1  final beat of packet.
- in_sel  input  1  route select (0 → out0, 1 → out1); sampled on first beat only.
- out0_valid  output  1  output 0 beat valid.
- out0_ready  input  1  output 0 consumer ready.
- out0_data  output  DW  output 0 data.
- out0_last  output  1  output 0 last flag.
- out1_valid / out1_ready / out1_data / out1_last: as for out0, for output 1.
- pkt_cnt0  output  CW  packets fully delivered into output 0 register (wraps).
- pkt_cnt1  output  CW  same for output 1.

Behaviour:
- Clocking and reset:
  - One clock. Reset is synchronous and active-high, ports named clk and rst.
  - On rst=1 at a clock edge: state=IDLE, out0_valid=out1_valid=0, out*_data=0, out*_last=0, pkt_cnt0=pkt_cnt1=0.
  - An in-flight packet is discarded; no partial completion and no counter increment.
- State machine: IDLE, PKT0, PKT1.
  - IDLE: target = in_sel (combinational).
  - First beat accepted with in_last=0: go to PKT0 or PKT1 per in_sel.
  - First beat accepted with in_last=1 (single-beat packet): stay IDLE.
  - PKT0/PKT1: target fixed; in_sel ignored. Accepting a beat with in_last=1 returns to IDLE.
- Output register per port:
  - Holds one beat {data, last}; valid set when a beat is written.
  - Valid cleared when out_valid && out_ready and no new write in the same cycle.
  - Simultaneous drain and write: register takes the new beat and valid stays 1. Full throughput is one beat per cycle per active port.
- Ready rule: in_ready = !target_valid || target_ready, where target is the selected output. Purely combinational from the current state, in_sel (IDLE only) and the target output's signals.
  - The non-target output never affects in_ready.
- Latency: accepted beat appears on its output's valid/data/last on the next cycle.
- Output stability: while out_valid=1 and out_ready=0, data/last/valid hold stable.
- Ordering: beats within a packet never reorder; packets to different outputs may drain independently.
  - While a packet to out0 is in progress, out1's register may still drain its held beat.
- Counters: pkt_cntN increments by 1 in the cycle a beat with in_last=1 is accepted toward output N.
  - Width CW, wraps from 2^CW−1 to 0 with no flag.
- in_valid=0: no state change, no writes; outputs keep draining.

Test Plan:
- Single-beat packet: in_sel=0, in_data=0xA5, in_last=1, out0_ready=1 → next cycle out0_valid=1, out0_data=0xA5, out0_last=1; out1_valid stays 0; pkt_cnt0=1; state IDLE.
- Sticky route: 3-beat packet 0x11, 0x22, 0x33 with in_sel=1 on beat 1 and toggled to 0 on beats 2–3 → all three beats appear on out1 in order, last only with 0x33; pkt_cnt1=1, pkt_cnt0=0.
- Backpressure: out0_ready=0 while sending 0x01, 0x02 to out0 → after the first beat in_ready=0; out0_data holds 0x01. Raise out0_ready → 0x01 consumed and 0x02 accepted the same cycle; no beat lost or duplicated.
- Independence: out1 holding a beat with out1_ready=0; send a packet to out0 → in_ready=1 and out0 packet flows at one beat per cycle; out1 beat unchanged.
- Counter wrap: send 256 single-beat packets to out0 with CW=8 → pkt_cnt0 returns to 0; pkt_cnt1 stays 0.
- Reset mid-packet: after 2 beats of a 4-beat packet to out1, assert rst for one cycle → out0_valid=out1_valid=0, counters 0, state IDLE. A subsequent packet with in_sel=0 routes to out0.
